key_input: RTL

Debounced push-button front end for the board's user keys; it is the input-side counterpart of the LED pattern drivers. Each active-low key pin is synchronised, debounced and classified into level, press, release, long-press and auto-repeat events. All outputs are single-cycle pulses or clean levels in the `sys_clk` domain, ready for LED/pattern control logic.

---
 rtl/key_input_pkg.sv | 24 ++
 rtl/key_fsm.sv | 143 ++++++++++++++
 rtl/key_input.sv | 42 ++++
 3 files changed

// File: rtl/key_input_pkg.sv
// Shared types and elaboration-time helpers for the debounced key front end.
package key_input_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_DB_PRESS   = 3'd1,
      ST_HELD       = 3'd2,
      ST_REPEAT     = 3'd3,
      ST_DB_RELEASE = 3'd4
   } key_state_e;

   function automatic int ms_to_cyc(input int clk_hz, input int ms);
      return clk_hz / 1000 * ms;
   endfunction

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_fsm.sv
// One key: 2-FF synchroniser, debounce/hold FSM and event pulse generation.
module key_fsm
   import key_input_pkg::*;
#(
   parameter int CLK_HZ      = 27_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
   localparam int REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);
   localparam int CW       = cnt_width(DB_CYC, LONG_CYC, REP_CYC);

   localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

   if (DB_CYC < 2 || LONG_CYC <= DB_CYC || REP_CYC < 2) begin : g_bad_params
      $error("key_fsm: invalid timing parameters");
   end

   logic [1:0]    r_sync;
   logic          w_pressed;
   key_state_e    r_state;
   key_state_e    r_origin;
   logic [CW-1:0] r_db_cnt;
   logic [CW-1:0] r_hold_cnt;
   logic          r_level;
   logic          r_press;
   logic          r_release;
   logic          r_long;
   logic          r_repeat;

   key_state_e    w_run_state;
   logic [CW-1:0] w_hold_nxt;
   logic          w_long;
   logic          w_repeat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], i_key_n};
   end

   assign w_pressed = ~r_sync[1];

   // Hold/repeat advance; applied on every HELD/REPEAT cycle, including the one that sees a release.
   always_comb begin
      w_run_state = r_state;
      w_hold_nxt  = r_hold_cnt + 1'b1;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      if (r_state == ST_HELD && r_hold_cnt == LONG_LAST) begin
         w_long      = 1'b1;
         w_hold_nxt  = '0;
         w_run_state = ST_REPEAT;
      end else if (r_state == ST_REPEAT && r_hold_cnt == REP_LAST) begin
         w_repeat    = 1'b1;
         w_hold_nxt  = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_origin   <= ST_HELD;
         r_db_cnt   <= '0;
         r_hold_cnt <= '0;
         r_level    <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pressed) begin
                  r_state  <= ST_DB_PRESS;
                  r_db_cnt <= '0;
               end
            end
            ST_DB_PRESS: begin
               if (!w_pressed) begin
                  r_state <= ST_IDLE;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state    <= ST_HELD;
                  r_press    <= 1'b1;
                  r_level    <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            ST_HELD, ST_REPEAT: begin
               r_hold_cnt <= w_hold_nxt;
               r_long     <= w_long;
               r_repeat   <= w_repeat;
               r_origin   <= w_run_state;
               if (!w_pressed) begin
                  r_state  <= ST_DB_RELEASE;
                  r_db_cnt <= '0;
               end else begin
                  r_state <= w_run_state;
               end
            end
            ST_DB_RELEASE: begin
               // Hold counter stays frozen here; a re-press resumes the origin state silently.
               if (w_pressed) begin
                  r_state <= r_origin;
               end else if (r_db_cnt == DB_LAST) begin
                  r_state   <= ST_IDLE;
                  r_release <= 1'b1;
                  r_level   <= 1'b0;
               end else begin
                  r_db_cnt <= r_db_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/key_input.sv
// Debounced multi-key front end: one key_fsm per pin plus an any-key level.
module key_input
   import key_input_pkg::*;
#(
   parameter int NUM_KEYS    = 2,
   parameter int CLK_HZ      = 27_000_000,
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int REPEAT_MS   = 200
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
   output logic [NUM_KEYS-1:0] long_pulse,
   output logic [NUM_KEYS-1:0] repeat_pulse,
   output logic                key_any
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
      key_fsm #(
         .CLK_HZ      (CLK_HZ),
         .DEBOUNCE_MS (DEBOUNCE_MS),
         .LONG_MS     (LONG_MS),
         .REPEAT_MS   (REPEAT_MS)
      ) u_key (
         .i_clk     (sys_clk),
         .i_rst     (sys_rst),
         .i_key_n   (key_n[g]),
         .o_level   (key_level[g]),
         .o_press   (press_pulse[g]),
         .o_release (release_pulse[g]),
         .o_long    (long_pulse[g]),
         .o_repeat  (repeat_pulse[g])
      );
   end

   assign key_any = |key_level;

endmodule
